// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data_memory port between the pipeline MEM stage (CPU
//   port) and a loader/debug port (LD port). The CPU has priority by default.
//   A starvation counter forces the loader onto the port once the CPU has been
//   granted STARVE_LIMIT consecutive cycles while the loader was waiting. A
//   forced grant then keeps the port for up to LD_HOLD loader beats.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   cpu_req/read/write    MEM stage request and strobes
//   cpu_addr/wdata        CPU address and write data
//   cpu_rdata             CPU read data, combinational from mem_rdata
//   cpu_stall             CPU denied this cycle (freeze the pipeline)
//   ld_valid/write/addr/wdata  loader beat offer
//   ld_ready              loader beat accepted this cycle
//   ld_rsp_valid/rdata    registered loader read response
//   mem_read/write/addr/wdata  drive the data_memory port
//   mem_rdata             data_memory read data, combinational
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LD_HOLD      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_valid,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  output logic              ld_rsp_valid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int HW = (LD_HOLD > 1) ? $clog2(LD_HOLD) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(LD_HOLD - 1);
  // A single-beat hold never needs the S_LD state.
  localparam bit HOLD_MULTI = (LD_HOLD > 1);

  typedef enum logic {S_CPU, S_LD} state_t;

  state_t            state_reg, state_next;
  logic [SW-1:0]     starve_cnt_reg, starve_cnt_next;
  logic [HW-1:0]     hold_cnt_reg, hold_cnt_next;
  logic              ld_rsp_valid_reg;
  logic [DATA_W-1:0] ld_rdata_reg;

  logic grant_cpu;
  logic grant_ld;
  logic force_ld;

  // Grant decision and next-state logic.
  always_comb begin
    grant_cpu       = 1'b0;
    grant_ld        = 1'b0;
    force_ld        = 1'b0;
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    case (state_reg)
      S_CPU: begin
        force_ld  = ld_valid && (starve_cnt_reg == STARVE_MAX);
        grant_cpu = cpu_req && !force_ld;
        grant_ld  = ld_valid && !grant_cpu;
        if (!ld_valid || grant_ld) begin
          starve_cnt_next = '0;
        end else if (grant_cpu && (starve_cnt_reg != STARVE_MAX)) begin
          starve_cnt_next = starve_cnt_reg + SW'(1);
        end
        // Only a contested forced grant opens a multi-beat hold; an
        // uncontested loader beat is served without changing state.
        if (HOLD_MULTI && force_ld && grant_ld && cpu_req) begin
          state_next    = S_LD;
          hold_cnt_next = HW'(1);
        end
      end
      S_LD: begin
        grant_ld  = ld_valid;
        // CPU takes the port in the same cycle the loader drops out.
        grant_cpu = cpu_req && !ld_valid;
        if (!ld_valid || (hold_cnt_reg == HOLD_LAST)) begin
          state_next      = S_CPU;
          hold_cnt_next   = '0;
          starve_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + HW'(1);
        end
      end
      default: begin
        state_next = S_CPU;
      end
    endcase
  end

  // Memory port mux.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_cpu) begin
      mem_read  = cpu_read;
      mem_write = cpu_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (grant_ld) begin
      mem_read  = !ld_write;
      mem_write = ld_write;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_CPU;
      starve_cnt_reg   <= '0;
      hold_cnt_reg     <= '0;
      ld_rsp_valid_reg <= 1'b0;
      ld_rdata_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      starve_cnt_reg   <= starve_cnt_next;
      hold_cnt_reg     <= hold_cnt_next;
      ld_rsp_valid_reg <= grant_ld && !ld_write;
      if (grant_ld && !ld_write) begin
        ld_rdata_reg <= mem_rdata;
      end
    end
  end

  assign cpu_rdata    = grant_cpu ? mem_rdata : '0;
  assign cpu_stall    = cpu_req && !grant_cpu;
  assign ld_ready     = grant_ld;
  assign ld_rsp_valid = ld_rsp_valid_reg;
  assign ld_rdata     = ld_rdata_reg;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory port between two requesters: the pipeline MEM stage (CPU port) and a loader/debug port (LD port).
- Default priority goes to the CPU. A starvation counter forces the loader onto the port after STARVE_LIMIT denied cycles, and a forced loader grant holds the port for up to LD_HOLD beats.
- cpu_stall tells the hazard/pipeline logic to freeze PC, IF/ID, ID/EX and EX/MEM while the CPU is denied.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, max consecutive CPU-granted cycles while the loader is pending; legal range >= 1.
- LD_HOLD, 2, max loader beats per forced grant; legal range >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage wants the memory this cycle (memRead | memWrite).
- cpu_read  in  1  CPU read strobe.
- cpu_write  in  1  CPU write strobe.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, combinational.
- cpu_stall  out  1  CPU denied this cycle.
- ld_valid  in  1  loader beat offered.
- ld_write  in  1  1 = write beat, 0 = read beat.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_ready  out  1  loader beat accepted this cycle.
- ld_rsp_valid  out  1  registered read response valid.
- ld_rdata  out  DATA_W  registered read response data.
- mem_read  out  1  to data_memory memRead.
- mem_write  out  1  to data_memory memWrite.
- mem_addr  out  ADDR_W  to data_memory address.
- mem_wdata  out  DATA_W  to data_memory writeData.
- mem_rdata  in  DATA_W  from data_memory memData, combinational.

Behaviour:
- States: S_CPU (reset state) and S_LD. Registers: state, starve_cnt (0..STARVE_LIMIT), hold_cnt (0..LD_HOLD-1), ld_rsp_valid, ld_rdata.
- Async reset (reset_n=0) forces state=S_CPU, starve_cnt=0, hold_cnt=0, ld_rsp_valid=0, ld_rdata=0. Reset mid-operation drops any pending response. The memory strobes fall to 0 immediately because cpu_req and ld_valid are held low by the sources during reset.
- S_CPU grant, combinational:
  - force = ld_valid & (starve_cnt == STARVE_LIMIT).
  - grant_cpu = cpu_req & ~force.
  - grant_ld = ld_valid & ~grant_cpu.
- S_LD grant, combinational:
  - grant_ld = ld_valid.
  - grant_cpu = cpu_req & ~ld_valid, so there is no dead cycle when the loader drops.
- Outputs:
  - ld_ready = grant_ld.
  - cpu_stall = cpu_req & ~grant_cpu.
- Memory mux:
  - grant_cpu: mem_* = cpu_*.
  - grant_ld: mem_read = ~ld_write, mem_write = ld_write, mem_addr/mem_wdata = ld_*.
  - No grant: all mem_* = 0.
- cpu_rdata = grant_cpu ? mem_rdata : 0. This gives zero-latency CPU access, matching the combinational memory read.
- Loader response:
  - At the edge after an accepted read beat (grant_ld & ~ld_write): ld_rsp_valid=1 and ld_rdata=mem_rdata. Otherwise ld_rsp_valid=0 and ld_rdata holds.
  - Writes produce no response. Back-to-back reads give back-to-back responses.
- starve_cnt, in S_CPU only:
  - Clear to 0 when ~ld_valid or grant_ld.
  - Otherwise +1 when grant_cpu & ld_valid, saturating at STARVE_LIMIT.
  - S_LD leaves it at 0.
- Transitions:
  - S_CPU -> S_LD when force & grant_ld & cpu_req and LD_HOLD > 1. Set hold_cnt=1.
  - S_CPU opportunistic grants (cpu_req low): single beat, no state change.
  - S_LD -> S_CPU when ~ld_valid, or when grant_ld & hold_cnt == LD_HOLD-1. Clear hold_cnt and starve_cnt.
  - Otherwise in S_LD: hold_cnt +1 per accepted beat.
  - LD_HOLD == 1: a forced grant is a single beat and stays in S_CPU.
- Simultaneous cpu_req & ld_valid below the limit: CPU wins and the counter increments.
- Neither requester active: idle, all strobes 0, cpu_stall=0, ld_ready=0.
- Stalled CPU: the CPU must hold cpu_* stable while cpu_stall=1. The loader must hold ld_* stable until ld_ready.
- Never assert mem_read and mem_write together unless the CPU drives both. Never grant both ports in one cycle.

Test Plan:
- Reset: assert reset_n=0 mid-S_LD with a read pending -> immediately state S_CPU, ld_rsp_valid=0, ld_rdata=0; after release with cpu_req=0 and ld_valid=0, all mem_* are 0.
- CPU only: cpu_read, addr=20, mem_rdata=0x6D -> same cycle mem_read=1, mem_addr=20, cpu_rdata=0x6D, cpu_stall=0.
- Opportunistic loader: cpu_req=0, ld read addr=40, mem_rdata=0x00FF00FF -> ld_ready=1 same cycle; next cycle ld_rsp_valid=1, ld_rdata=0x00FF00FF.
- Starvation (STARVE_LIMIT=4, LD_HOLD=2), cpu_req and ld_valid held high:
  - Cycles 1-4: CPU granted, starve_cnt 1..4.
  - Cycles 5-6: loader granted with cpu_stall=1.
  - Cycle 7: CPU granted again, starve_cnt=0.
- Early release: in S_LD, ld_valid drops after 1 beat with cpu_req=1 -> the next cycle grants the CPU with no idle cycle and cpu_stall=0.
- Loader write during CPU idle: ld_write, addr=8, wdata=0xDEADBEEF -> mem_write=1, mem_wdata=0xDEADBEEF; next cycle ld_rsp_valid=0.
